alu_result_checker: RTL and testbench

- Response-side companion to the 64-bit ALU: consumes ALU outputs (result, zero) paired with expected values, one vector per handshake.
- Counts vectors and mismatches, captures the first failing vector, and reports pass/fail once a programmed number of vectors has been checked.
- Used as an on-chip self-check sink behind the ALU in BIST and FPGA bring-up builds.

---
 rtl/alu_result_checker.sv | 119 +++++++++++
 tb/tb_alu_result_checker.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/alu_result_checker.sv
// Self-check sink for the 64-bit ALU: compares result/zero against golden values per handshake,
// counts vectors and mismatches, captures the first failure and reports pass/fail after NUM_VECTORS.
module alu_result_checker #(
  parameter int N           = 64,
  parameter int NUM_VECTORS = 21,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     result,
  input  logic             zero,
  input  logic [N-1:0]     expected_result,
  input  logic             expected_zero,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vector_count,
  output logic [CNT_W-1:0] error_count,
  output logic             first_err_valid,
  output logic [CNT_W-1:0] first_err_index,
  output logic [N-1:0]     first_err_result,
  output logic             first_err_zero
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VECTORS - 1);

  state_t           state_r;
  logic             xfer_s;
  logic             mismatch_s;
  logic             last_s;
  logic [CNT_W-1:0] err_next_s;

  // Transfer qualification, compare and saturating error increment
  always_comb begin
    xfer_s     = in_valid & in_ready;
    mismatch_s = (result != expected_result) | (zero != expected_zero);
    last_s     = (vector_count == LAST_IDX);
    if (mismatch_s && !(&error_count)) begin
      err_next_s = error_count + CNT_W'(1);
    end else begin
      err_next_s = error_count;
    end
  end

  // Run-control FSM; all status outputs registered so in_ready depends only on state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r          <= ST_IDLE;
      in_ready         <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      vector_count     <= '0;
      error_count      <= '0;
      first_err_valid  <= 1'b0;
      first_err_index  <= '0;
      first_err_result <= '0;
      first_err_zero   <= 1'b0;
    end else if (start) begin
      // start overrides any same-cycle transfer, which is dropped
      state_r          <= ST_RUN;
      in_ready         <= 1'b1;
      busy             <= 1'b1;
      done             <= 1'b0;
      pass             <= 1'b0;
      vector_count     <= '0;
      error_count      <= '0;
      first_err_valid  <= 1'b0;
      first_err_index  <= '0;
      first_err_result <= '0;
      first_err_zero   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_r <= ST_IDLE;
        end
        ST_RUN: begin
          if (xfer_s) begin
            vector_count <= vector_count + CNT_W'(1);
            error_count  <= err_next_s;
            if (mismatch_s && !first_err_valid) begin
              first_err_valid  <= 1'b1;
              first_err_index  <= vector_count;
              first_err_result <= result;
              first_err_zero   <= zero;
            end
            if (last_s) begin
              state_r  <= ST_DONE;
              in_ready <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              pass     <= (err_next_s == '0);
            end
          end
        end
        ST_DONE: begin
          state_r <= ST_DONE;
        end
        default: begin
          state_r  <= ST_IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
          pass     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_result_checker.sv
// Randomized self-checking bench for alu_result_checker against a run-level reference model.
module tb_alu_result_checker;
  localparam int N = 64;
  localparam int NV = 21;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          reset, start, in_valid, zero, expected_zero;
  logic [N-1:0]  result, expected_result;
  logic          in_ready, busy, done, pass, first_err_valid, first_err_zero;
  logic [CW-1:0] vector_count, error_count, first_err_index;
  logic [N-1:0]  first_err_result;

  int checks = 0;
  int failures = 0;

  // reference model: run phase 0=idle 1=run 2=done plus run statistics
  int            m_phase;
  int unsigned   m_vc, m_ec;
  bit            m_fev, m_fez;
  int unsigned   m_fei;
  logic [N-1:0]  m_fer;

  alu_result_checker #(.N(N), .NUM_VECTORS(NV), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .result(result), .zero(zero), .expected_result(expected_result),
    .expected_zero(expected_zero), .busy(busy), .done(done), .pass(pass),
    .vector_count(vector_count), .error_count(error_count),
    .first_err_valid(first_err_valid), .first_err_index(first_err_index),
    .first_err_result(first_err_result), .first_err_zero(first_err_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_vc = 0; m_ec = 0; m_fev = 0; m_fei = 0; m_fer = '0; m_fez = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".in_ready"}, N'(in_ready), N'(m_phase == 1));
    chk({tag, ".busy"}, N'(busy), N'(m_phase == 1));
    chk({tag, ".done"}, N'(done), N'(m_phase == 2));
    chk({tag, ".pass"}, N'(pass), N'(m_phase == 2 && m_ec == 0));
    chk({tag, ".vector_count"}, N'(vector_count), N'(m_vc));
    chk({tag, ".error_count"}, N'(error_count), N'(m_ec));
    chk({tag, ".first_err_valid"}, N'(first_err_valid), N'(m_fev));
    chk({tag, ".first_err_index"}, N'(first_err_index), N'(m_fei));
    chk({tag, ".first_err_result"}, first_err_result, m_fer);
    chk({tag, ".first_err_zero"}, N'(first_err_zero), N'(m_fez));
  endtask

  // one clock: drive inputs, let the edge happen, advance model, compare
  task automatic step(input string tag, input bit st, input bit v, input logic [N-1:0] r,
                      input bit z, input logic [N-1:0] er, input bit ez);
    bit mm;
    start = st; in_valid = v; result = r; zero = z; expected_result = er; expected_zero = ez;
    @(posedge clk);
    if (st) begin
      m_phase = 1; model_clear();
    end else if (m_phase == 1 && v) begin
      mm = (r != er) || (z != ez);
      if (mm && !m_fev) begin
        m_fev = 1; m_fei = m_vc; m_fer = r; m_fez = z;
      end
      if (mm && m_ec != 32'hFFFF_FFFF) m_ec++;
      m_vc++;
      if (m_vc == NV) m_phase = 2;
    end
    #1;
    check_all(tag);
  endtask

  task automatic rand_vec(input int bad_pct, output logic [N-1:0] r, output bit z,
                          output logic [N-1:0] er, output bit ez);
    er = {$urandom(), $urandom()};
    ez = (er == '0);
    r = er; z = ez;
    if ($urandom_range(99) < bad_pct) begin
      if ($urandom_range(1) == 0) r = er ^ (N'(1) << $urandom_range(N - 1));
      else z = ~ez;
    end
  endtask

  logic [N-1:0] r, er, a, b;
  bit z, ez;
  int budget;

  initial begin
    reset = 1'b1; start = 0; in_valid = 0; result = '0; zero = 0;
    expected_result = '0; expected_zero = 0;
    m_phase = 0; model_clear();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    reset = 1'b0;
    step("idle_valid", 0, 1, 64'h1, 0, 64'h2, 0);

    // run 1: all matching, valid held high
    step("start1", 1, 0, '0, 0, '0, 0);
    for (int i = 0; i < NV; i++) begin
      a = {$urandom(), $urandom()}; b = {$urandom(), $urandom()};
      if (i == 0) begin a = 64'h191; b = 64'h529; end
      step("run1", 0, 1, a & b, (a & b) == '0, 64'h101 & ((i == 0) ? 64'hFFFF : 64'h0) | ((i == 0) ? 64'h0 : (a & b)), (a & b) == '0);
    end
    chk("run1.final_vc", N'(vector_count), N'(NV));
    chk("run1.pass", N'(pass), N'(1));
    step("done_valid_ignored", 0, 1, 64'h5, 0, 64'h6, 0);

    // run 2: vector 3 wrong result, vector 7 wrong zero flag; started from DONE
    step("start2", 1, 0, '0, 0, '0, 0);
    for (int i = 0; i < NV; i++) begin
      rand_vec(0, r, z, er, ez);
      if (i == 3) begin r = 64'h6B9; er = 64'h6BA; z = 0; ez = 0; end
      if (i == 7) begin z = 1; ez = 0; er = 64'h77; r = 64'h77; end
      step("run2", 0, 1, r, z, er, ez);
    end
    chk("run2.errors", N'(error_count), N'(2));
    chk("run2.first_idx", N'(first_err_index), N'(3));
    chk("run2.first_res", first_err_result, 64'h6B9);

    // run 3: gapped valid 1,0,0,1 with overflow-style vectors and random errors
    step("start3", 1, 0, '0, 0, '0, 0);
    budget = 0;
    while (m_phase == 1 && budget < 200) begin
      rand_vec(25, r, z, er, ez);
      if (m_vc == 4) begin r = 64'hFFFF_FFFF_FFFF_FFFE; er = r; z = 0; ez = 0; end
      if (m_vc == 5) begin r = 64'hFFFF_FFFF_FFFF_FFFE; er = '0; z = 0; ez = 1; end
      step("run3", 0, (budget % 4 == 0) || (budget % 4 == 3), r, z, er, ez);
      budget++;
    end
    chk("run3.terminated", N'(m_phase), N'(2));
    chk("run3.final_vc", N'(vector_count), N'(NV));

    // run 4: start mid-run at vector_count 10 with valid high drops that transfer
    step("start4", 1, 0, '0, 0, '0, 0);
    for (int i = 0; i < 10; i++) begin
      rand_vec(30, r, z, er, ez);
      step("run4", 0, 1, r, z, er, ez);
    end
    step("restart_mid", 1, 1, 64'h1, 0, 64'h2, 0);
    chk("restart.vc", N'(vector_count), N'(0));

    // async reset mid-cycle during RUN
    for (int i = 0; i < 3; i++) begin
      rand_vec(50, r, z, er, ez);
      step("run5", 0, 1, r, z, er, ez);
    end
    #2 reset = 1'b1;
    #1;
    m_phase = 0; model_clear();
    check_all("async_reset");
    #1 reset = 1'b0;
    step("post_reset_valid", 0, 1, 64'h3, 0, 64'h4, 0);
    step("post_reset_valid2", 0, 1, 64'h3, 0, 64'h3, 0);

    // random runs with occasional restarts
    for (int k = 0; k < 4; k++) begin
      step("start_rnd", 1, 0, '0, 0, '0, 0);
      budget = 0;
      while (m_phase == 1 && budget < 300) begin
        rand_vec(40, r, z, er, ez);
        step("rnd", ($urandom_range(99) < 2), ($urandom_range(99) < 70), r, z, er, ez);
        budget++;
      end
      chk("rnd.terminated", N'(m_phase), N'(2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
